// File: rtl/complex_dot_product_feeder_if.sv
// Bus bundle between the dot-product feeder and its environment.
// The master modport is the feeder side. It takes the controller start and bases,
// the memory read data and the engine status, and drives the memory reads, the row
// packages, the engine reset and the completion status. The slave modport is the
// environment side (controller, memories and engine).
interface complex_dot_product_feeder_if #(
  parameter int unsigned element_width = 64,
  parameter int unsigned NI            = 8,
  parameter int unsigned AW            = 8
);
  logic                          start;
  logic [AW-1:0]                 a_base;
  logic [AW-1:0]                 b_base;
  logic                          mem_rd_en;
  logic [AW-1:0]                 mem_a_addr;
  logic [AW-1:0]                 mem_b_addr;
  logic [element_width*NI-1:0]   mem_a_data;
  logic [element_width*NI-1:0]   mem_b_data;
  logic [element_width*NI-1:0]   first_row_output;
  logic [element_width*NI-1:0]   second_row_output;
  logic                          read_now;
  logic                          dp_reset;
  logic                          dp_finish;
  logic [element_width-1:0]      dp_result;
  logic [element_width-1:0]      result;
  logic                          result_valid;
  logic                          timeout_err;
  logic                          busy;

  modport master (
    input  start, a_base, b_base, mem_a_data, mem_b_data, dp_finish, dp_result,
    output mem_rd_en, mem_a_addr, mem_b_addr, first_row_output, second_row_output,
           read_now, dp_reset, result, result_valid, timeout_err, busy
  );

  modport slave (
    output start, a_base, b_base, mem_a_data, mem_b_data, dp_finish, dp_result,
    input  mem_rd_en, mem_a_addr, mem_b_addr, first_row_output, second_row_output,
           read_now, dp_reset, result, result_valid, timeout_err, busy
  );
endinterface

// File: rtl/complex_dot_product_feeder.sv
// Sequencer feeding the complex dot-product engine from two vector memories.
// On start it resets the engine and fetches each operand package. It zero-masks
// lanes past NOE and presents each package for HOLD cycles with a one-cycle
// read_now strobe. It then waits for dp_finish (bounded by TIMEOUT) and reports
// the latched result.
// Ports: clk, reset (sync, active-high), bus (master modport of
// complex_dot_product_feeder_if: controller, memory and engine signals).
module complex_dot_product_feeder #(
  parameter int unsigned element_width = 64,
  parameter int unsigned NOE           = 8,
  parameter int unsigned NI            = 8,
  parameter int unsigned HOLD          = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned AW            = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  complex_dot_product_feeder_if.master  bus
);
  localparam int unsigned PKG = NOE / NI + 1;
  localparam int unsigned RW  = element_width * NI;
  localparam int unsigned PW  = $clog2(PKG + 1);
  localparam int unsigned HW  = $clog2(HOLD + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, WAIT_RD, PRESENT, WAIT_FIN, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            pkg_q, pkg_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic [TW-1:0]            wait_q, wait_d;
  logic [AW-1:0]            a_base_q, a_base_d, b_base_q, b_base_d;
  logic [AW-1:0]            a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [RW-1:0]            row_a_q, row_a_d, row_b_q, row_b_d;
  logic [element_width-1:0] result_q, result_d;
  logic                     rd_en_q, rd_en_d;
  logic                     read_now_q, read_now_d;
  logic                     result_valid_q, result_valid_d;
  logic                     timeout_q, timeout_d;
  logic                     busy_q, busy_d;
  logic [RW-1:0]            lane_mask;

  // Lane k of the current package is valid only while its element index is below NOE.
  for (genvar k = 0; k < NI; k++) begin : g_lane
    assign lane_mask[element_width*(NI-k)-1 -: element_width] =
      {element_width{(32'(pkg_q) * NI + 32'(k)) < NOE}};
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d        = state_q;
    pkg_d          = pkg_q;
    hold_d         = hold_q;
    wait_d         = wait_q;
    a_base_d       = a_base_q;
    b_base_d       = b_base_q;
    a_addr_d       = a_addr_q;
    b_addr_d       = b_addr_q;
    row_a_d        = row_a_q;
    row_b_d        = row_b_q;
    result_d       = result_q;
    rd_en_d        = 1'b0;
    read_now_d     = 1'b0;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_base_d = bus.a_base;
          b_base_d = bus.b_base;
          pkg_d    = '0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        rd_en_d  = 1'b1;
        a_addr_d = a_base_q + AW'(pkg_q);
        b_addr_d = b_base_q + AW'(pkg_q);
        state_d  = FETCH;
      end
      FETCH: state_d = WAIT_RD;
      WAIT_RD: begin
        row_a_d    = bus.mem_a_data & lane_mask;
        row_b_d    = bus.mem_b_data & lane_mask;
        read_now_d = 1'b1;
        hold_d     = '0;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (hold_q == HW'(HOLD - 1)) begin
          if (pkg_q == PW'(PKG - 1)) begin
            row_a_d = '0;
            row_b_d = '0;
            wait_d  = '0;
            state_d = WAIT_FIN;
          end else begin
            pkg_d    = pkg_q + PW'(1);
            rd_en_d  = 1'b1;
            a_addr_d = a_base_q + AW'(pkg_q + PW'(1));
            b_addr_d = b_base_q + AW'(pkg_q + PW'(1));
            state_d  = FETCH;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      WAIT_FIN: begin
        // A finish seen in the last allowed cycle still wins over the timeout.
        if (bus.dp_finish) begin
          result_d       = bus.dp_result;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pkg_q          <= '0;
      hold_q         <= '0;
      wait_q         <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
      a_addr_q       <= '0;
      b_addr_q       <= '0;
      row_a_q        <= '0;
      row_b_q        <= '0;
      result_q       <= '0;
      rd_en_q        <= 1'b0;
      read_now_q     <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkg_q          <= pkg_d;
      hold_q         <= hold_d;
      wait_q         <= wait_d;
      a_base_q       <= a_base_d;
      b_base_q       <= b_base_d;
      a_addr_q       <= a_addr_d;
      b_addr_q       <= b_addr_d;
      row_a_q        <= row_a_d;
      row_b_q        <= row_b_d;
      result_q       <= result_d;
      rd_en_q        <= rd_en_d;
      read_now_q     <= read_now_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  // The engine is held in reset with the block and pulsed once per run from CLEAR.
  assign bus.dp_reset          = reset | (state_q == CLEAR);
  assign bus.mem_rd_en         = rd_en_q;
  assign bus.mem_a_addr        = a_addr_q;
  assign bus.mem_b_addr        = b_addr_q;
  assign bus.first_row_output  = row_a_q;
  assign bus.second_row_output = row_b_q;
  assign bus.read_now          = read_now_q;
  assign bus.result            = result_q;
  assign bus.result_valid      = result_valid_q;
  assign bus.timeout_err       = timeout_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Self-checking bench for complex_dot_product_feeder.
// The expected behaviour is taken from the timing rules: with PKG=2 and HOLD=4,
// cycle c is counted from the start edge. CLEAR falls at c=1, FETCH at
// 2+6p, read_now at 4+6p, the presentation window is 4+6p..7+6p, and WAIT_FIN
// starts at 14. Expected packages come from the memory contents masked by NOE.
module tb_complex_dot_product_feeder;
  localparam int unsigned EW = 64;
  localparam int unsigned NI = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = EW * NI;
  localparam int WF = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  complex_dot_product_feeder_if #(.element_width(EW), .NI(NI), .AW(AW)) if0 ();
  complex_dot_product_feeder_if #(.element_width(EW), .NI(NI), .AW(AW)) if1 ();

  complex_dot_product_feeder #(.element_width(EW), .NOE(8), .NI(NI), .HOLD(4),
                               .TIMEOUT(64), .AW(AW)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  complex_dot_product_feeder #(.element_width(EW), .NOE(12), .NI(NI), .HOLD(4),
                               .TIMEOUT(64), .AW(AW)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [RW-1:0] ma0 [256];
  logic [RW-1:0] mb0 [256];
  logic [RW-1:0] ma1 [256];
  logic [RW-1:0] mb1 [256];

  int n_cmp = 0;
  int n_bad = 0;

  // Synchronous-read memories: data valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (if0.mem_rd_en) begin
      if0.mem_a_data <= ma0[if0.mem_a_addr];
      if0.mem_b_data <= mb0[if0.mem_b_addr];
    end
    if (if1.mem_rd_en) begin
      if1.mem_a_data <= ma1[if1.mem_a_addr];
      if1.mem_b_data <= mb1[if1.mem_b_addr];
    end
  end

  function automatic logic [RW-1:0] rand_word();
    logic [RW-1:0] w;
    for (int i = 0; i < RW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Package p as the engine should see it: element p*NI+k in lane k, zero past noe.
  function automatic logic [RW-1:0] exp_pkg(input logic [RW-1:0] word, input int p, input int noe);
    logic [RW-1:0] w;
    w = word;
    for (int k = 0; k < NI; k++)
      if (p * NI + k >= noe) w[EW*(NI-k)-1 -: EW] = '0;
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if0.dp_reset, if0.busy, if0.mem_rd_en, if0.read_now, if0.result_valid, if0.timeout_err} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b exp 100000",
               {if0.dp_reset, if0.busy, if0.mem_rd_en, if0.read_now, if0.result_valid, if0.timeout_err});
    end
    n_cmp++;
    if ((if0.first_row_output | if0.second_row_output) !== '0 || if0.result !== '0 ||
        if0.mem_a_addr !== '0 || if0.mem_b_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_data got result=%h addr=%h/%h exp zeros", if0.result, if0.mem_a_addr, if0.mem_b_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if0.dp_reset, if0.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release got %b exp 00", {if0.dp_reset, if0.busy});
    end
  endtask

  // Full runs: directed vectors, address wrap, stale dp_finish, then random data.
  task automatic test_random_runs();
    for (int it = 0; it < 6; it++) begin
      logic [AW-1:0] ab, bb;
      logic [EW-1:0] res;
      logic [RW-1:0] wa [2];
      logic [RW-1:0] wb [2];
      logic [5:0]    obs, expc;
      int            fin;
      bit            stale;
      ab    = AW'($urandom);
      bb    = AW'($urandom);
      res   = {$urandom, $urandom} | 64'd1;
      fin   = WF + $urandom_range(0, 10);
      stale = (it == 2);
      if (it == 0) begin ab = 8'h00; bb = 8'h40; fin = 20; res = 64'h0000_0064_0000_0003; end
      if (it == 1) ab = 8'hFF;
      if (stale) fin = WF;
      for (int p = 0; p < 2; p++) begin wa[p] = rand_word(); wb[p] = rand_word(); end
      if (it == 0)
        for (int k = 0; k < NI; k++) begin
          wa[0][EW*(NI-k)-1 -: EW] = EW'(k + 1);
          wb[0][EW*(NI-k)-1 -: EW] = EW'(k + 9);
        end
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        ma0[AW'(int'(ab) + p)] = wa[p];
        mb0[AW'(int'(bb) + p)] = wb[p];
      end
      if0.a_base = ab; if0.b_base = bb; if0.dp_result = res; if0.start = 1'b1;
      for (int c = 1; c <= fin + 2; c++) begin
        @(negedge clk);
        if0.start = 1'b0;
        obs  = {if0.busy, if0.dp_reset, if0.mem_rd_en, if0.read_now, if0.result_valid, if0.timeout_err};
        expc = {c <= fin + 1, c == 1, c >= 2 && c < WF && (c - 2) % 6 == 0,
                c >= 4 && c < WF && (c - 4) % 6 == 0, c == fin + 1, 1'b0};
        n_cmp++;
        if (obs !== expc) begin
          n_bad++;
          $display("FAIL run%0d_ctrl c=%0d got %b exp %b (busy,dprst,rd,rn,rv,to)", it, c, obs, expc);
        end
        if (c >= 2 && c < WF && (c - 2) % 6 == 0) begin
          n_cmp++;
          if (if0.mem_a_addr !== AW'(int'(ab) + (c - 2) / 6) || if0.mem_b_addr !== AW'(int'(bb) + (c - 2) / 6)) begin
            n_bad++;
            $display("FAIL run%0d_addr c=%0d got %h/%h exp %h/%h", it, c, if0.mem_a_addr, if0.mem_b_addr,
                     AW'(int'(ab) + (c - 2) / 6), AW'(int'(bb) + (c - 2) / 6));
          end
        end
        if (c >= WF || (c >= 4 && (c - 4) % 6 < 4)) begin
          logic [RW-1:0] ea, eb;
          ea = (c >= WF) ? '0 : exp_pkg(wa[(c - 4) / 6], (c - 4) / 6, 8);
          eb = (c >= WF) ? '0 : exp_pkg(wb[(c - 4) / 6], (c - 4) / 6, 8);
          n_cmp++;
          if (if0.first_row_output !== ea || if0.second_row_output !== eb) begin
            n_bad++;
            $display("FAIL run%0d_rows c=%0d got %h exp %h", it, c, if0.first_row_output, ea);
          end
        end
        if (c == fin + 1) begin
          n_cmp++;
          if (if0.result !== res) begin
            n_bad++;
            $display("FAIL run%0d_result got %h exp %h", it, if0.result, res);
          end
        end
        if0.dp_finish = stale || (c >= fin);
      end
      if0.dp_finish = (it == 1);
    end
  endtask

  task automatic test_timeout();
    int rv_seen;
    rv_seen = 0;
    @(negedge clk);
    if0.a_base = AW'($urandom); if0.b_base = AW'($urandom); if0.dp_finish = 1'b0; if0.start = 1'b1;
    for (int c = 1; c <= WF + 65; c++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.result_valid) rv_seen++;
      if (c == WF + 63) begin
        n_cmp++;
        if ({if0.busy, if0.timeout_err} !== 2'b10) begin
          n_bad++;
          $display("FAIL timeout_early got %b exp 10", {if0.busy, if0.timeout_err});
        end
      end
      if (c == WF + 64) begin
        n_cmp++;
        if (if0.timeout_err !== 1'b1 || if0.result !== '0) begin
          n_bad++;
          $display("FAIL timeout_pulse got to=%b result=%h exp to=1 result=0", if0.timeout_err, if0.result);
        end
      end
      if (c == WF + 65) begin
        n_cmp++;
        if ({if0.busy, if0.timeout_err} !== 2'b00) begin
          n_bad++;
          $display("FAIL timeout_after got %b exp 00", {if0.busy, if0.timeout_err});
        end
      end
    end
    n_cmp++;
    if (rv_seen !== 0) begin
      n_bad++;
      $display("FAIL timeout_no_valid got %0d exp 0", rv_seen);
    end
  endtask

  task automatic test_start_while_busy();
    logic [AW-1:0] ab;
    int dpr;
    dpr = 0;
    ab  = AW'($urandom);
    @(negedge clk);
    if0.a_base = ab; if0.start = 1'b1; if0.dp_finish = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (if0.dp_reset) dpr++;
      if (c == 8) begin
        n_cmp++;
        if (if0.mem_rd_en !== 1'b1 || if0.mem_a_addr !== AW'(int'(ab) + 1)) begin
          n_bad++;
          $display("FAIL busy_start_addr got rd=%b addr=%h exp rd=1 addr=%h", if0.mem_rd_en, if0.mem_a_addr, AW'(int'(ab) + 1));
        end
      end
      if (c == 15 || c == 17) begin
        n_cmp++;
        if ({if0.busy, if0.result_valid} !== ((c == 15) ? 2'b11 : 2'b00)) begin
          n_bad++;
          $display("FAIL busy_start_end c=%0d got %b", c, {if0.busy, if0.result_valid});
        end
      end
      if0.start  = (c == 5 || c == 11);
      if0.a_base = ab + 8'h20;
      if0.dp_finish = (c >= WF && c <= WF + 1);
    end
    n_cmp++;
    if (dpr !== 1) begin
      n_bad++;
      $display("FAIL busy_start_dpreset got %0d exp 1", dpr);
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] res;
    int rn;
    rn  = 0;
    res = {$urandom, $urandom};
    @(negedge clk);
    if0.a_base = AW'($urandom); if0.start = 1'b1; if0.dp_finish = 1'b0;
    for (int c = 1; c <= 11; c++) begin @(negedge clk); if0.start = 1'b0; end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (if0.dp_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_dpreset got %b exp 1", if0.dp_reset);
    end
    @(negedge clk);
    n_cmp++;
    if ({if0.dp_reset, if0.busy, if0.mem_rd_en, if0.read_now, if0.result_valid, if0.timeout_err} !== 6'b100000 ||
        (if0.first_row_output | if0.second_row_output) !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got %b exp 100000",
               {if0.dp_reset, if0.busy, if0.mem_rd_en, if0.read_now, if0.result_valid, if0.timeout_err});
    end
    reset = 1'b0;
    @(negedge clk);
    if0.dp_result = res; if0.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.read_now) rn++;
      if (c == 15) begin
        n_cmp++;
        if (if0.result_valid !== 1'b1 || if0.result !== res) begin
          n_bad++;
          $display("FAIL midreset_rerun got rv=%b result=%h exp rv=1 result=%h", if0.result_valid, if0.result, res);
        end
      end
      if0.dp_finish = (c >= WF);
    end
    if0.dp_finish = 1'b0;
    n_cmp++;
    if (rn !== 2 || if0.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_rerun_shape got read_now=%0d busy=%b exp 2/0", rn, if0.busy);
    end
  endtask

  task automatic test_noe12();
    logic [RW-1:0] half;
    int rn;
    rn   = 0;
    half = {{(RW/2){1'b1}}, {(RW/2){1'b0}}};
    for (int i = 0; i < 256; i++) begin ma1[i] = '1; mb1[i] = '1; end
    @(negedge clk);
    if1.a_base = AW'($urandom); if1.b_base = AW'($urandom); if1.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if1.start = 1'b0;
      if (if1.read_now) rn++;
      if (c == 4 || c == 10) begin
        n_cmp++;
        if (if1.first_row_output !== ((c == 4) ? '1 : half) || if1.second_row_output !== ((c == 4) ? '1 : half)) begin
          n_bad++;
          $display("FAIL noe12_pkg c=%0d got %h", c, if1.first_row_output);
        end
      end
      if (c == 15) begin
        n_cmp++;
        if (if1.result_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL noe12_valid got %b exp 1", if1.result_valid);
        end
      end
      if1.dp_finish = (c >= WF);
    end
    n_cmp++;
    if (rn !== 2) begin
      n_bad++;
      $display("FAIL noe12_read_now got %0d exp 2", rn);
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.a_base = '0; if0.b_base = '0; if0.dp_finish = 1'b0; if0.dp_result = '0;
    if1.start = 1'b0; if1.a_base = '0; if1.b_base = '0; if1.dp_finish = 1'b0; if1.dp_result = 64'h1234;
    test_reset();
    test_random_runs();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    test_noe12();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/complex_dot_product_feeder.md
# complex_dot_product_feeder

Sequencer that drives the complex dot-product engine from two vector memories. On `start` it clears the engine, fetches both operand vectors package by package (NI complex elements per package), zero-pads past NOE, and presents each package with a one-cycle `read_now` strobe. It then waits for the engine's `finish`, latches the 64-bit complex result, and reports completion to the controller.

## Interface
- `element_width`, 64, bits per complex element, opaque to this block.
- `NOE`, 8, number of valid elements per vector.
- `NI`, 8, elements per package, even, ≥2.
- `HOLD`, 4, cycles each package is held on the outputs, ≥3.
- `TIMEOUT`, 64, maximum cycles spent waiting for `dp_finish`.
- `AW`, 8, memory address width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin one dot product. Ignored unless `busy`=0.
- `a_base` in AW: word address of package 0 of vector A. Sampled with `start`.
- `b_base` in AW: word address of package 0 of vector B. Sampled with `start`.
- `mem_rd_en` out 1: read strobe for both memories.
- `mem_a_addr`, `mem_b_addr` out AW: read addresses.
- `mem_a_data`, `mem_b_data` in element_width*NI: read data, valid the cycle after `mem_rd_en`.
- `first_row_output`, `second_row_output` out element_width*NI: package to the engine.
- `read_now` out 1: one-cycle package strobe.
- `dp_reset` out 1: engine reset.
- `dp_finish` in 1: engine done, level.
- `dp_result` in element_width: engine result.
- `result` out element_width: latched dot product.
- `result_valid` out 1: one-cycle completion pulse.
- `timeout_err` out 1: one-cycle pulse when the wait for `dp_finish` times out.
- `busy` out 1: high in every state except IDLE.

## Operation
- Package count: PKG = NOE/NI + 1, using integer division. This always includes one trailing package, which is all zeros when NOE%NI==0. This matches the engine's fixed package count.
- Lane k of package p sits at bits [element_width*(NI-k)-1 -: element_width] and holds element p*NI+k. Lanes where p*NI+k ≥ NOE are forced to zero on both outputs, whatever the memory returns.
- Memory addresses for package p are `a_base`+p and `b_base`+p, modulo 2^AW (wrap allowed).
- FSM states: IDLE, CLEAR, FETCH, WAIT_RD, PRESENT, WAIT_FIN, DONE.
  - IDLE: on `start`, latch the bases, set p=0, go to CLEAR.
  - CLEAR: `dp_reset`=1 for 1 cycle, then FETCH.
  - FETCH: `mem_rd_en`=1 with the addresses for p, then WAIT_RD.
  - WAIT_RD: register the masked memory data into the row outputs at the end of this cycle, then PRESENT.
  - PRESENT: lasts HOLD cycles. `read_now`=1 in the first cycle only. Row outputs stay stable for the whole state. Afterwards go to FETCH with p+1 if p<PKG-1, else WAIT_FIN.
  - WAIT_FIN: the row outputs are driven to zero. If `dp_finish`=1, latch `dp_result` into `result` and go to DONE. If TIMEOUT cycles elapse first, set `result`=0, pulse `timeout_err`, and go to IDLE.
  - DONE: `result_valid`=1 for 1 cycle, then IDLE.
- `dp_reset` = `reset` OR (state==CLEAR).
- `dp_finish` is ignored outside WAIT_FIN, including a stale high left over from a previous run.
- `start` while `busy`=1 is ignored and has no side effects.
- A `start` in the same cycle the FSM returns to IDLE is not accepted. It must be applied again in IDLE.

## Timing
- `start` sampled high at cycle 0 (edge E0).
  - CLEAR: cycle 1.
  - FETCH for package 0: cycle 2.
  - WAIT_RD: cycle 3.
  - First `read_now`: cycle 4.
- Each package occupies HOLD+2 cycles. The first `read_now` of package p falls at cycle 4 + p*(HOLD+2).
- WAIT_FIN begins at cycle 2 + PKG*(HOLD+2).
- If `dp_finish` is seen in WAIT_FIN cycle t, then `result` updates and `result_valid`=1 in cycle t+1. `busy` drops in cycle t+2.
- Reset values: all outputs 0 except `dp_reset`=1 while `reset`=1. State=IDLE, p=0.
- `reset` mid-operation aborts in the next cycle with all outputs back to reset values. No `result_valid` or `timeout_err` pulse is produced.

## Test plan
- NOE=8, NI=8, HOLD=4, A[0] lanes = 1..8, B[0] lanes = 9..16.
  - Expect: package 0 passes through unmasked, package 1 is all zeros.
  - Expect: `read_now` at cycles 4 and 10.
  - Engine stub raises `dp_finish` at cycle 20 with 0x0000_0064_0000_0003, giving `result`=0x0000_0064_0000_0003 and `result_valid` at cycle 21.
- NOE=12, NI=8, memory filled with 0xFFFF_FFFF_FFFF_FFFF.
  - Expect: package 1 lanes 0-3 all-ones, lanes 4-7 zero.
  - Expect: exactly 2 `read_now` pulses.
- `a_base`=0xFF, NOE=8.
  - Expect: addresses 0xFF then 0x00 (wrap).
- `dp_finish` never asserted, TIMEOUT=64.
  - Expect: `timeout_err` pulse 64 cycles after WAIT_FIN entry, `result`=0, `busy`=0 next cycle.
- `start` pulsed during PRESENT.
  - Expect: no restart, no extra `dp_reset`.
- `dp_finish` held high from the previous run at the new `start`.
  - Expect: ignored until WAIT_FIN.
- `reset` asserted during PRESENT of package 1.
  - Expect: `dp_reset`=1, all outputs 0 and IDLE next cycle.
  - Expect: a following `start` completes normally.
